// File: rtl/ad_capture_pack.sv
// Trigger-started A/D capture engine: delay, decimate or peak-hold,
// then pack PACK results per output word with valid/last/done strobes.
//
// Ports:
//   i_ad_clk      sample clock (only clock)
//   i_rst         async active-high reset
//   i_st          start strobe, rising edge triggers a capture
//   i_abort       synchronous abort of the capture in progress
//   i_ad_data     unsigned A/D sample
//   i_recv_count  result samples per capture
//   i_delay       clocks skipped after the trigger
//   i_dec         decimation ratio (0 and 1 mean none)
//   i_mode        0 = first sample of window, 1 = window max
//   o_data        packed word, earliest result in the low lane
//   o_valid       one-cycle word strobe
//   o_last        final word of the capture
//   o_working     capture in progress
//   o_done        one-cycle normal-completion pulse
module ad_capture_pack #(
    parameter int DSIZE  = 8,
    parameter int PACK   = 2,
    parameter int CWIDTH = 16,
    parameter int DECW   = 4
) (
    input  logic                  i_ad_clk,
    input  logic                  i_rst,
    input  logic                  i_st,
    input  logic                  i_abort,
    input  logic [DSIZE-1:0]      i_ad_data,
    input  logic [CWIDTH-1:0]     i_recv_count,
    input  logic [CWIDTH-1:0]     i_delay,
    input  logic [DECW-1:0]       i_dec,
    input  logic                  i_mode,
    output logic [DSIZE*PACK-1:0] o_data,
    output logic                  o_valid,
    output logic                  o_last,
    output logic                  o_working,
    output logic                  o_done
);

    localparam int LW = (PACK > 1) ? $clog2(PACK) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DELAY,
        S_CAPT,
        S_FLUSH
    } state_t;

    state_t                r_state;
    logic                  r_st_d;
    logic [CWIDTH-1:0]     r_recv;
    logic [CWIDTH-1:0]     r_dcnt;
    logic [CWIDTH-1:0]     r_rcnt;
    logic [DECW-1:0]       r_dmax;
    logic                  r_mode;
    logic [DECW-1:0]       r_wcnt;
    logic [DSIZE-1:0]      r_first;
    logic [DSIZE-1:0]      r_max;
    logic [LW-1:0]         r_lane;
    logic [DSIZE*PACK-1:0] r_pack;

    logic                  w_trig;
    logic                  w_wfirst;
    logic                  w_wend;
    logic                  w_lfull;
    logic                  w_rlast;
    logic [CWIDTH-1:0]     w_rnext;
    logic [DSIZE-1:0]      w_max;
    logic [DSIZE-1:0]      w_res;
    logic [DSIZE*PACK-1:0] w_word;

    assign w_trig   = i_st & ~r_st_d;
    assign w_wfirst = (r_wcnt == '0);
    assign w_wend   = (r_wcnt == r_dmax);
    assign w_lfull  = (r_lane == LW'(PACK - 1));
    assign w_rnext  = r_rcnt + CWIDTH'(1);
    assign w_rlast  = (w_rnext == r_recv);

    // The first sample of a window restarts the running max.
    assign w_max = w_wfirst ? i_ad_data :
                   ((i_ad_data > r_max) ? i_ad_data : r_max);
    assign w_res = r_mode ? w_max :
                   (w_wfirst ? i_ad_data : r_first);

    // Lane 0 opens a fresh word so a flushed partial word has zero upper lanes.
    always_comb begin
        w_word = r_pack;
        if (r_lane == '0) begin
            w_word = '0;
        end
        w_word[int'(r_lane)*DSIZE +: DSIZE] = w_res;
    end

    always_ff @(posedge i_ad_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_st_d    <= 1'b1;
            r_recv    <= '0;
            r_dcnt    <= '0;
            r_rcnt    <= '0;
            r_dmax    <= '0;
            r_mode    <= 1'b0;
            r_wcnt    <= '0;
            r_first   <= '0;
            r_max     <= '0;
            r_lane    <= '0;
            r_pack    <= '0;
            o_data    <= '0;
            o_valid   <= 1'b0;
            o_last    <= 1'b0;
            o_working <= 1'b0;
            o_done    <= 1'b0;
        end else begin
            r_st_d  <= i_st;
            o_valid <= 1'b0;
            o_last  <= 1'b0;
            o_done  <= 1'b0;
            if (r_state != S_IDLE && i_abort) begin
                r_state   <= S_IDLE;
                o_working <= 1'b0;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        if (w_trig && !i_abort) begin
                            r_recv <= i_recv_count;
                            r_dcnt <= i_delay;
                            r_mode <= i_mode;
                            r_dmax <= (i_dec <= DECW'(1)) ? '0 :
                                      i_dec - DECW'(1);
                            r_rcnt <= '0;
                            r_wcnt <= '0;
                            r_lane <= '0;
                            if (i_recv_count == '0) begin
                                o_done <= 1'b1;
                            end else if (i_delay != '0) begin
                                r_state   <= S_DELAY;
                                o_working <= 1'b1;
                            end else begin
                                r_state   <= S_CAPT;
                                o_working <= 1'b1;
                            end
                        end
                    end
                    S_DELAY: begin
                        r_dcnt <= r_dcnt - CWIDTH'(1);
                        if (r_dcnt == CWIDTH'(1)) begin
                            r_state <= S_CAPT;
                        end
                    end
                    S_CAPT: begin
                        r_max <= w_max;
                        if (w_wfirst) begin
                            r_first <= i_ad_data;
                        end
                        if (w_wend) begin
                            r_wcnt <= '0;
                            r_pack <= w_word;
                            r_rcnt <= w_rnext;
                            r_lane <= w_lfull ? '0 : r_lane + LW'(1);
                            if (w_lfull) begin
                                o_data  <= w_word;
                                o_valid <= 1'b1;
                            end
                            if (w_rlast) begin
                                if (w_lfull) begin
                                    o_last    <= 1'b1;
                                    o_done    <= 1'b1;
                                    o_working <= 1'b0;
                                    r_state   <= S_IDLE;
                                end else begin
                                    r_state <= S_FLUSH;
                                end
                            end
                        end else begin
                            r_wcnt <= r_wcnt + DECW'(1);
                        end
                    end
                    S_FLUSH: begin
                        o_data    <= r_pack;
                        o_valid   <= 1'b1;
                        o_last    <= 1'b1;
                        o_done    <= 1'b1;
                        o_working <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/ad_capture_pack.md
Name: ad_capture_pack

Overview:
Trigger-started A/D capture engine, parametrised successor to the dual-sample AD buffer. On a rising edge of the start strobe it waits a programmable delay, then captures a programmable number of decimated or peak-held samples. Results are packed PACK-per-word into a wide output word with a one-cycle valid strobe. It sits between the A/D front end (same clock domain) and the acquisition FIFO/transfer logic.

Parameters:
DSIZE, 8, A/D sample width in bits.
PACK, 2, samples packed per output word (>=1).
CWIDTH, 16, width of the sample-count and delay registers.
DECW, 4, width of the decimation-ratio input.

Ports:
i_ad_clk  in  1  A/D sample clock; only clock.
i_rst  in  1  reset, asynchronous, active-high.
i_st  in  1  start strobe; a rising edge triggers a capture.
i_abort  in  1  synchronous abort of the capture in progress.
i_ad_data  in  DSIZE  A/D sample, unsigned.
i_recv_count  in  CWIDTH  number of result samples to produce.
i_delay  in  CWIDTH  clocks to skip between trigger and first captured sample.
i_dec  in  DECW  decimation ratio D; 0 and 1 both mean no decimation.
i_mode  in  1  0 = pick the first sample of each window, 1 = peak-hold (unsigned max of the window).
o_data  out  DSIZE*PACK  packed word; earliest sample in bits [DSIZE-1:0].
o_valid  out  1  one-cycle strobe; o_data is valid when high.
o_last  out  1  high with o_valid on the final word of a capture.
o_working  out  1  high while a capture is in progress.
o_done  out  1  one-cycle pulse on normal completion.

Behaviour:
- Reset (async, i_rst=1): state IDLE; all counters, o_data, o_valid, o_last, o_working, o_done = 0; start-edge history register = 1, so i_st held high through reset does not trigger.
- Edge detect: trigger cycle k = first edge where i_st=1 and the previous sample of i_st=0. Edges while not IDLE are ignored.
- At the trigger edge: latch i_recv_count, i_delay, i_dec, i_mode; later changes to these inputs have no effect until the next trigger.
- States: IDLE -> DELAY (latched delay != 0) or CAPTURE (delay = 0) -> FLUSH (only if a partial word remains) -> IDLE.
- Latched recv_count=0: go straight to IDLE, pulse o_done at k+1, no o_valid.
- o_working = 1 from edge k+1 until the edge that returns to IDLE.
- DELAY: discard samples at edges k+1 .. k+delay.
- CAPTURE: the first captured sample is i_ad_data at edge k+1+delay. Windows are D consecutive samples, D = max(i_dec,1).
  - Mode 0: the result is the first sample of the window.
  - Mode 1: the result is the max over all D samples; a running max register is reinitialised by the window's first sample.
- Each completed window produces one result. Results shift into the pack register at lane index = result count mod PACK.
- When PACK results are collected: o_valid=1 on the next cycle, with o_data holding the full word.
- When the result count reaches the latched recv_count:
  - Full word: its o_valid carries o_last=1 and o_done pulses in the same cycle.
  - Partial word: FLUSH emits it on the next cycle with unfilled upper lanes = 0, o_valid=o_last=o_done=1.
- o_data holds its value between strobes. It changes only with o_valid, or at reset.
- i_abort=1 in any non-IDLE state: next state IDLE, partial word discarded, no o_valid/o_last/o_done, o_working low the next cycle. i_abort in IDLE has no effect. i_abort and a trigger edge on the same cycle: abort wins, no capture.
- Counters are CWIDTH bits; recv_count = 2^CWIDTH-1 must complete without wrap. The delay counter is sized identically.
- Reset asserted mid-capture: immediate return to reset values, no o_done.

Test Plan:
- DSIZE=8, PACK=2, delay=0, D=1, mode 0, recv_count=4, ramp data 0x10,0x11,... from edge k+1 -> o_valid at k+3 (0x1110) and k+5 (0x1312) with o_last, o_done at k+5, o_working low after.
- PACK=4, recv_count=5, delay=3 -> first sample is the 4th post-trigger sample; one full word, then FLUSH word with lanes 1-3 = 0 and o_last=o_done=1.
- D=4, mode 1, windows {3,9,2,7},{5,5,1,0}, PACK=2, recv_count=2 -> single word 0x0509 with o_last.
- i_st held high through reset release -> no capture; drop i_st then raise it -> capture starts. Second edge mid-capture is ignored.
- i_abort during CAPTURE after 1 of 2 results -> no o_valid, no o_done; o_working low next cycle; a new trigger captures normally.
- recv_count=0 -> o_done pulse at k+1, o_valid never asserted.
